// File: rtl/sign_ext_pkg.sv
// Extension modes and instruction field widths shared by the sign-extension pipe.
package sign_ext_pkg;

  typedef enum logic [2:0] {
    SIMM13   = 3'd0,
    DISP22   = 3'd1,
    DISP30   = 3'd2,
    DISP30X4 = 3'd3,
    SETHI    = 3'd4,
    DISP22X4 = 3'd5
  } mode_e;

  localparam int SIMM13_W = 13;
  localparam int DISP22_W = 22;
  localparam int DISP30_W = 30;

endpackage

// File: rtl/sign_ext_fifo.sv
// Generic FIFO. Pop data is combinational from the head entry; no push/pop bypass.
// Push is ignored when full and pop when empty; the storage array is not reset.
module sign_ext_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         full,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push    = push_vld && !full;
  assign pop     = pop_rdy && !empty;
  assign pop_dat = mem[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= push_dat;
  end

endmodule

// File: rtl/sign_ext_pipe.sv
// Instruction immediate extender: one-cycle latency through a FIFO, in_ready = not full.
// SIGN_EXT_ERR_EN adds out_err, flagging sel 6/7, carried alongside each entry.
module sign_ext_pipe
  import sign_ext_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       ir,
  input  logic [2:0]        sel,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef SIGN_EXT_ERR_EN
  output logic              out_err,
`endif
  output logic [DATA_W-1:0] out_data
);

`ifdef SIGN_EXT_ERR_EN
  localparam int EW = DATA_W + 1;
`else
  localparam int EW = DATA_W;
`endif

  logic [DATA_W-1:0] ext;
  logic [EW-1:0]     push_dat, head;
  logic              full, empty;
  logic              up_q, up_d;

  always_comb begin
    ext = '0;
    case (sel)
      SIMM13: begin
        ext = {DATA_W{ir[SIMM13_W-1]}};
        ext[SIMM13_W-1:0] = ir[SIMM13_W-1:0];
      end
      DISP22: begin
        ext = {DATA_W{ir[DISP22_W-1]}};
        ext[DISP22_W-1:0] = ir[DISP22_W-1:0];
      end
      DISP30: begin
        ext = {DATA_W{ir[DISP30_W-1]}};
        ext[DISP30_W-1:0] = ir[DISP30_W-1:0];
      end
      DISP30X4: begin
        ext = {DATA_W{ir[DISP30_W-1]}};
        ext[DISP30_W+1:0] = {ir[DISP30_W-1:0], 2'b00};
      end
      SETHI: begin
        ext = '0;
        ext[31:10] = ir[DISP22_W-1:0];
      end
      DISP22X4: begin
        ext = {DATA_W{ir[DISP22_W-1]}};
        ext[DISP22_W+1:0] = {ir[DISP22_W-1:0], 2'b00};
      end
      default: ext = '0;
    endcase
  end

`ifdef SIGN_EXT_ERR_EN
  assign push_dat = {(sel[2] & sel[1]), ext};
  assign out_err  = empty ? 1'b0 : head[DATA_W];
`else
  assign push_dat = ext;
`endif

  // in_ready stays low through reset and rises on the first edge after release.
  assign up_d      = 1'b1;
  assign in_ready  = up_q && !full;
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : head[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) up_q <= 1'b0;
    else        up_q <= up_d;
  end

  sign_ext_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (in_valid && in_ready),
    .push_dat (push_dat),
    .full     (full),
    .pop_rdy  (out_ready),
    .pop_dat  (head),
    .empty    (empty)
  );

endmodule

// File: tb/tb_sign_ext_pipe.sv
// Directed vectors against 32- and 64-bit instances sharing the same stimulus.
module tb_sign_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] ir = '0;
  logic [2:0]  sel = '0;
  logic        in_ready32, in_ready64, out_valid32, out_valid64;
  logic [31:0] out_data32;
  logic [63:0] out_data64;
  logic        err32, err64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sign_ext_pipe #(.DATA_W(32), .FIFO_DEPTH(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .ir(ir), .sel(sel), .out_valid(out_valid32), .out_ready(out_ready),
`ifdef SIGN_EXT_ERR_EN
    .out_err(err32),
`endif
    .out_data(out_data32)
  );

  sign_ext_pipe #(.DATA_W(64), .FIFO_DEPTH(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .ir(ir), .sel(sel), .out_valid(out_valid64), .out_ready(out_ready),
`ifdef SIGN_EXT_ERR_EN
    .out_err(err64),
`endif
    .out_data(out_data64)
  );

`ifndef SIGN_EXT_ERR_EN
  assign err32 = 1'b0;
  assign err64 = 1'b0;
`endif

  typedef struct {
    logic [31:0] ir;
    logic [2:0]  sel;
    logic [63:0] exp;
    logic        err;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [63:0] exp, input logic err);
    check({name, " valid32"}, {63'd0, out_valid32}, 64'd1);
    check({name, " valid64"}, {63'd0, out_valid64}, 64'd1);
    check({name, " data32"}, {32'd0, out_data32}, {32'd0, exp[31:0]});
    check({name, " data64"}, out_data64, exp);
`ifdef SIGN_EXT_ERR_EN
    check({name, " err32"}, {63'd0, err32}, {63'd0, err});
    check({name, " err64"}, {63'd0, err64}, {63'd0, err});
`endif
  endtask

  task automatic check_rdy(input string name, input logic exp);
    check({name, " in_ready32"}, {63'd0, in_ready32}, {63'd0, exp});
    check({name, " in_ready64"}, {63'd0, in_ready64}, {63'd0, exp});
  endtask

  initial begin
    vecs[0]  = '{32'h0000_1FFF, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[1]  = '{32'h0000_0FFF, 3'd0, 64'h0000_0000_0000_0FFF, 1'b0};
    vecs[2]  = '{32'h2000_0000, 3'd3, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[3]  = '{32'h003F_FFFF, 3'd4, 64'h0000_0000_FFFF_FC00, 1'b0};
    vecs[4]  = '{32'h0020_0001, 3'd5, 64'hFFFF_FFFF_FF80_0004, 1'b0};
    vecs[5]  = '{32'h0020_0000, 3'd1, 64'hFFFF_FFFF_FFE0_0000, 1'b0};
    vecs[6]  = '{32'h001F_FFFF, 3'd1, 64'h0000_0000_001F_FFFF, 1'b0};
    vecs[7]  = '{32'h2000_0001, 3'd2, 64'hFFFF_FFFF_E000_0001, 1'b0};
    vecs[8]  = '{32'h1FFF_FFFF, 3'd2, 64'h0000_0000_1FFF_FFFF, 1'b0};
    vecs[9]  = '{32'hFFFF_FFFF, 3'd6, 64'h0, 1'b1};
    vecs[10] = '{32'hFFFF_FFFF, 3'd7, 64'h0, 1'b1};
    vecs[11] = '{32'hDFFF_FFFF, 3'd3, 64'h0000_0000_7FFF_FFFC, 1'b0};
    vecs[12] = '{32'hABCD_E123, 3'd4, 64'h0000_0000_3784_8C00, 1'b0};
    vecs[13] = '{32'h0000_1000, 3'd0, 64'hFFFF_FFFF_FFFF_F000, 1'b0};

    // Reset state
    #2;
    check("rst valid32", {63'd0, out_valid32}, 64'd0);
    check("rst valid64", {63'd0, out_valid64}, 64'd0);
    check("rst data64", out_data64, 64'd0);
    check_rdy("rst", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_rdy("post-rst", 1'b1);

    // Table: single word through an empty FIFO, one cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      ir = vecs[i].ir; sel = vecs[i].sel; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_out($sformatf("vec%0d", i), vecs[i].exp, vecs[i].err);
      @(posedge clk); #1;
      check($sformatf("vec%0d drained", i), {63'd0, out_valid64}, 64'd0);
    end

    // Back-to-back throughput with out_ready held high
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ir = 32'h10 + i; sel = 3'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      check_out($sformatf("stream%0d", i), 64'h10 + i, 1'b0);
      check_rdy($sformatf("stream%0d", i), 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Fill to full, hold head, pop once, then accept the third word
    @(negedge clk);
    out_ready = 1'b0; ir = 32'hA; sel = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    ir = 32'hB;
    @(posedge clk); #1;
    check_rdy("full", 1'b0);
    check_out("full head A", 64'hA, 1'b0);
    @(negedge clk);
    ir = 32'hC;
    @(posedge clk); #1;
    check_out("stall head A", 64'hA, 1'b0);
    check_rdy("stall", 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_rdy("after pop", 1'b1);
    check_out("head B", 64'hB, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_rdy("full again", 1'b0);
    check_out("held B", 64'hB, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_out("head C", 64'hC, 1'b0);
    @(posedge clk); #1;
    check("order drained", {63'd0, out_valid32}, 64'd0);

    // Asynchronous reset with two entries buffered
    @(negedge clk);
    out_ready = 1'b0; ir = 32'h1; sel = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    ir = 32'h2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_out("pre-rst head", 64'h1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async rst valid32", {63'd0, out_valid32}, 64'd0);
    check("async rst valid64", {63'd0, out_valid64}, 64'd0);
    check("async rst data32", {32'd0, out_data32}, 64'd0);
    check_rdy("async rst", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_rdy("rst release", 1'b1);
    @(negedge clk);
    out_ready = 1'b1; ir = 32'h0000_0123; sel = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_out("first after rst", 64'h123, 1'b0);
    @(posedge clk); #1;
    check("post-rst drained", {63'd0, out_valid64}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
